kyber_rej_uniform_stream: RTL and testbench

Streaming, parametrised rejection sampler for Kyber matrix generation. It takes a valid/ready byte-beat stream from the SHAKE/XOF squeeze stage and parses it into candidate coefficients. Candidates below the bound are accepted and emitted in order through a valid/ready coefficient stream with a small FIFO. It stops after exactly N accepted coefficients. It sits between the Keccak squeeze logic and the polynomial RAM/NTT writer. It replaces whole-array, fixed-size sampling with back-pressured streaming, and supports both the 12-bit and the 16-bit legacy parse.

---
 rtl/kyber_rej_uniform_stream.sv | 188 ++++++++++++++++++
 tb/tb_kyber_rej_uniform_stream.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/kyber_rej_uniform_stream.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : kyber_rej_uniform_stream                                         |
// | Streaming Kyber rejection sampler: XOF byte beats in, accepted            |
// | coefficients out through a small FIFO. Legacy 16-bit parse: define       |
// | KYBER_REJ_LEGACY16_EN.                                                    |
// | Rev    : 1.0                                                              |
// +---------------------------------------------------------------------------+
module kyber_rej_uniform_stream #(
  parameter int KYBER_N      = 256,
  parameter int KYBER_Q      = 3329,
  parameter int COEFF_W      = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int LEGACY_BOUND = 19 * KYBER_Q
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       i_mode,
  input  logic [23:0]                i_beat,
  input  logic                       i_beat_valid,
  output logic                       i_beat_ready,
  output logic [COEFF_W-1:0]         o_coeff,
  output logic [$clog2(KYBER_N)-1:0] o_coeff_idx,
  output logic                       o_coeff_valid,
  input  logic                       o_coeff_ready,
  output logic                       o_busy,
  output logic                       o_done
);
  localparam int IDX_W  = $clog2(KYBER_N);
  localparam int CNT_W  = IDX_W + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic [COEFF_W-1:0]  fifo_val_q [FIFO_DEPTH];
  logic [IDX_W-1:0]    fifo_idx_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]   count_q;

  logic               w_fire, w_pop, w_legacy;
  logic [11:0]        w_d1, w_d2;
  logic               w_d1_ok, w_d2_ok, w_last1;
  logic               w_c0_ok, w_c1_ok, w_p0, w_p1, w_we0, w_we1;
  logic [COEFF_W-1:0] w_c0_val, w_c1_val, w_val0;
  logic [1:0]         w_npush;
  logic [CNT_W-1:0]   w_acc_p1;
  logic [PTR_W-1:0]   w_wr1;

  assign o_coeff_valid = (count_q != '0);
  assign o_coeff       = o_coeff_valid ? fifo_val_q[rd_ptr_q] : '0;
  assign o_coeff_idx   = o_coeff_valid ? fifo_idx_q[rd_ptr_q] : '0;
  assign o_busy        = (state_q != ST_IDLE);
  assign w_pop         = o_coeff_valid && o_coeff_ready;

  // Two free slots are required so a full 12-bit beat can always land.
  assign i_beat_ready = (state_q == ST_RUN)
                     && ((FCNT_W'(FIFO_DEPTH) - count_q) >= FCNT_W'(2))
                     && (acc_cnt_q < CNT_W'(KYBER_N));
  assign w_fire = i_beat_valid && i_beat_ready && !clear;

  assign w_d1     = {i_beat[11:8], i_beat[7:0]};
  assign w_d2     = {i_beat[23:16], i_beat[15:12]};
  assign w_d1_ok  = 32'(w_d1) < KYBER_Q;
  assign w_d2_ok  = 32'(w_d2) < KYBER_Q;
  assign w_acc_p1 = acc_cnt_q + CNT_W'(1);
  assign w_last1  = (w_acc_p1 == CNT_W'(KYBER_N));

`ifdef KYBER_REJ_LEGACY16_EN
  logic               mode_q;
  logic [15:0]        w_v;
  logic               w_leg_ok;
  logic [COEFF_W-1:0] w_leg_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 1'b0;
    end else if (!clear && (state_q == ST_IDLE) && start) begin
      mode_q <= i_mode;
    end
  end

  assign w_v       = i_beat[15:0];
  assign w_leg_ok  = 32'(w_v) < LEGACY_BOUND;
  assign w_leg_val = COEFF_W'(32'(w_v) - 32'(w_v[15:12]) * KYBER_Q);
  assign w_legacy  = mode_q;
  assign w_c0_ok   = w_legacy ? w_leg_ok  : w_d1_ok;
  assign w_c0_val  = w_legacy ? w_leg_val : COEFF_W'(w_d1);
  assign w_c1_ok   = !w_legacy && w_d2_ok && !(w_d1_ok && w_last1);
`else
  logic w_unused;
  assign w_unused = ^{i_mode, LEGACY_BOUND};
  assign w_legacy = 1'b0;
  assign w_c0_ok  = w_d1_ok;
  assign w_c0_val = COEFF_W'(w_d1);
  assign w_c1_ok  = w_d2_ok && !(w_d1_ok && w_last1);
`endif
  assign w_c1_val = COEFF_W'(w_d2);

  // Accepted candidates are packed: the first goes to wr_ptr, a second to wr_ptr+1.
  assign w_p0    = w_fire && w_c0_ok;
  assign w_p1    = w_fire && w_c1_ok;
  assign w_we0   = w_p0 || w_p1;
  assign w_we1   = w_p0 && w_p1;
  assign w_val0  = w_p0 ? w_c0_val : w_c1_val;
  assign w_npush = {1'b0, w_p0} + {1'b0, w_p1};
  assign w_wr1   = wr_ptr_q + PTR_W'(1);

  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_we0 && (PTR_W'(i) == wr_ptr_q)) begin
        fifo_val_q[i] <= w_val0;
        fifo_idx_q[i] <= acc_cnt_q[IDX_W-1:0];
      end
      if (w_we1 && (PTR_W'(i) == w_wr1)) begin
        fifo_val_q[i] <= w_c1_val;
        fifo_idx_q[i] <= w_acc_p1[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(w_npush);
      rd_ptr_q <= rd_ptr_q + PTR_W'(w_pop);
      count_q  <= count_q + FCNT_W'(w_npush) - FCNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      acc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    o_done    = 1'b0;
    if (clear) begin
      state_d   = ST_IDLE;
      acc_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_RUN;
            acc_cnt_d = '0;
          end
        end
        ST_RUN: begin
          acc_cnt_d = acc_cnt_q + CNT_W'(w_npush);
          if (acc_cnt_q == CNT_W'(KYBER_N)) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (count_q == '0) begin
            state_d = ST_IDLE;
            o_done  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_kyber_rej_uniform_stream.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : tb_kyber_rej_uniform_stream                                      |
// | Directed self-checking bench for kyber_rej_uniform_stream.                |
// | Rev    : 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_kyber_rej_uniform_stream;
  logic        clk = 1'b0;
  logic        reset, clear, start, i_mode;
  logic [23:0] i_beat;
  logic        i_beat_valid, i_beat_ready;
  logic [15:0] o_coeff;
  logic [7:0]  o_coeff_idx;
  logic        o_coeff_valid, o_coeff_ready, o_busy, o_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pops   = 0;
  int n_done   = 0;
  int n_fires  = 0;
  int done_pops = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  kyber_rej_uniform_stream dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .start         (start),
    .i_mode        (i_mode),
    .i_beat        (i_beat),
    .i_beat_valid  (i_beat_valid),
    .i_beat_ready  (i_beat_ready),
    .o_coeff       (o_coeff),
    .o_coeff_idx   (o_coeff_idx),
    .o_coeff_valid (o_coeff_valid),
    .o_coeff_ready (o_coeff_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    if (o_coeff_valid && o_coeff_ready) begin
      got_q.push_back({8'h00, o_coeff_idx, o_coeff});
      n_pops++;
    end
    if (i_beat_valid && i_beat_ready) n_fires++;
    if (o_done) begin
      n_done++;
      done_pops = n_pops;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic exp_push(input int idx, input int val);
    exp_q.push_back({8'h00, 8'(idx), 16'(val)});
  endtask

  task automatic start_poly(input logic m);
    i_mode = m;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic send_beat(input logic [23:0] b);
    int t;
    t = 0;
    i_beat       = b;
    i_beat_valid = 1'b1;
    @(negedge clk);
    while (!i_beat_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("beat_ready", 32'(i_beat_ready), 32'd1);
    @(posedge clk); #1;
    i_beat_valid = 1'b0;
  endtask

  task automatic drain_check();
    logic [31:0] g, e;
    for (int t = 0; t < 100 && got_q.size() < exp_q.size(); t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("pop_count", 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk("pop_entry", g, e);
    end
    got_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int pops_base, done_base, fire_base;
    reset = 1'b1; clear = 1'b0; start = 1'b0; i_mode = 1'b0;
    i_beat = '0; i_beat_valid = 1'b0; o_coeff_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(o_busy),        32'd0);
    chk("rst_ready", 32'(i_beat_ready),  32'd0);
    chk("rst_valid", 32'(o_coeff_valid), 32'd0);
    chk("rst_coeff", 32'(o_coeff),       32'd0);
    chk("rst_idx",   32'(o_coeff_idx),   32'd0);
    chk("rst_done",  32'(o_done),        32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 12-bit basics and rejections
    pops_base = n_pops;
    done_base = n_done;
    start_poly(1'b0);
    chk("busy_run", 32'(o_busy), 32'd1);
    send_beat(24'h030201); exp_push(0, 513); exp_push(1, 48);
    drain_check();
    send_beat(24'hFFFFFF);
    send_beat(24'h010D00); exp_push(2, 3328); exp_push(3, 16);
    send_beat(24'h000D01); exp_push(4, 0);
    drain_check();

    // Fill to 255, then a final beat whose d2 must be dropped
    for (int k = 0; k < 125; k++) begin
      send_beat(24'h030201);
      exp_push(5 + 2 * k, 513);
      exp_push(6 + 2 * k, 48);
    end
    send_beat(24'h030201); exp_push(255, 513);
    repeat (2) @(negedge clk);
    chk("term_ready_low", 32'(i_beat_ready), 32'd0);
    @(posedge clk); #1;
    drain_check();
    for (int t = 0; t < 50 && n_done == done_base; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_pulses", 32'(n_done - done_base), 32'd1);
    chk("pops_at_done", 32'(done_pops - pops_base), 32'd256);
    chk("busy_after_done", 32'(o_busy), 32'd0);
    @(posedge clk); #1;

    // Backpressure: only two beats fit in a 4-deep FIFO
    start_poly(1'b0);
    o_coeff_ready = 1'b0;
    fire_base = n_fires;
    i_beat = 24'h030201;
    i_beat_valid = 1'b1;
    repeat (8) @(negedge clk);
    chk("bp_fires", 32'(n_fires - fire_base), 32'd2);
    chk("bp_ready_low", 32'(i_beat_ready), 32'd0);
    chk("bp_valid", 32'(o_coeff_valid), 32'd1);
    chk("bp_head_coeff", 32'(o_coeff), 32'd513);
    chk("bp_head_idx", 32'(o_coeff_idx), 32'd0);
    @(posedge clk); #1;
    i_beat_valid = 1'b0;
    o_coeff_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_push(2 * k, 513);
      exp_push(2 * k + 1, 48);
    end
    send_beat(24'h030201);
    send_beat(24'h030201);
    drain_check();

    // Clear mid-RUN with a full FIFO
    o_coeff_ready = 1'b0;
    send_beat(24'h030201);
    send_beat(24'h030201);
    done_base = n_done;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clr_busy", 32'(o_busy), 32'd0);
    chk("clr_valid", 32'(o_coeff_valid), 32'd0);
    chk("clr_ready", 32'(i_beat_ready), 32'd0);
    repeat (5) @(negedge clk);
    chk("clr_no_done", 32'(n_done - done_base), 32'd0);
    chk("clr_no_pops", 32'(got_q.size()), 32'd0);
    @(posedge clk); #1;
    o_coeff_ready = 1'b1;
    start_poly(1'b0);
    send_beat(24'h030201); exp_push(0, 513); exp_push(1, 48);
    drain_check();

`ifdef KYBER_REJ_LEGACY16_EN
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    start_poly(1'b1);
    send_beat(24'h001234); exp_push(0, 1331);
    send_beat(24'h00F000); exp_push(1, 11505);
    send_beat(24'h00FFFF);
    send_beat(24'hAB0001); exp_push(2, 1);
    drain_check();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
